// File: rtl/noc_pkg.sv
// Shared definitions for the NoC link transmit path.
//   FLIT_W_DEFAULT   : default flit width (FIFO data width)
//   FT_HEAD/BODY/TAIL/SINGLE : flit type codes held in the top two flit bits
//   state_t          : transmit framing FSM states (S_IDLE, S_PKT)
package noc_pkg;

  localparam int FLIT_W_DEFAULT = 16;

  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PKT  = 1'b1
  } state_t;

endpackage

// File: rtl/noc_credit_counter.sv
// Credit counter for credit-based link flow control.
//   clk, reset : clock, synchronous active-high reset (count reloads CREDITS)
//   inc        : downstream returned one buffer slot this cycle
//   dec        : one flit is sent this cycle (caller only asserts when avail)
//   avail      : at least one credit is held (count != 0)
//   overflow   : combinational pulse, credit returned while already full and
//                no flit is consuming one
//   count      : current credit count
module noc_credit_counter #(
  parameter int  CREDITS = 16,
  localparam int CW      = $clog2(CREDITS) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  output logic          avail,
  output logic          overflow,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] FULL = CW'(CREDITS);

  assign avail    = (count != '0);
  assign overflow = inc && !dec && (count == FULL);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= FULL;
    end else begin
      case ({inc, dec})
        // A spurious extra credit saturates at FULL; overflow flags it.
        2'b10: if (count != FULL) count <= count + CW'(1);
        // Floor guard: dec should never arrive with zero credits.
        2'b01: if (count != '0)   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noc_link_tx.sv
// Transmit end of a router output port.
// Pops flits from the output FIFO, forwards them onto the link one cycle
// later, enforces credit-based flow control, tracks packet framing and counts
// completed packets.
//   clk, reset   : clock, synchronous active-high reset
//   tx_en        : permission to pop new flits
//   fifo_empty   : FIFO empty flag
//   fifo_data    : FIFO head flit (combinational, valid while !fifo_empty)
//   fifo_read    : FIFO pop strobe (combinational)
//   link_valid   : link_flit carries a flit this cycle (registered)
//   link_flit    : outgoing flit (registered, holds when not valid)
//   credit_in    : downstream freed one slot (one-cycle pulse)
//   tx_busy      : a multi-flit packet is open
//   pkt_count    : completed packets, wraps
//   err_proto    : sticky framing / credit protocol error
//   state_dbg    : framing FSM state, for observation
//   credits_dbg  : credit counter value, for observation
//
// Handshake: the FIFO side is a pop interface. fifo_read is asserted exactly
// when a flit is taken this cycle (tx_en, data present, credit held, not in
// reset); the flit on fifo_data is consumed at that same clock edge and shows
// up on link_flit with link_valid=1 in the following cycle. The link side has
// no ready: a credit held guarantees the downstream slot.
module noc_link_tx
  import noc_pkg::*;
#(
  parameter int  FLIT_W  = FLIT_W_DEFAULT,
  parameter int  CREDITS = 16,
  parameter int  CNT_W   = 16,
  localparam int CW      = $clog2(CREDITS) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_en,
  input  logic              fifo_empty,
  input  logic [FLIT_W-1:0] fifo_data,
  output logic              fifo_read,
  output logic              link_valid,
  output logic [FLIT_W-1:0] link_flit,
  input  logic              credit_in,
  output logic              tx_busy,
  output logic [CNT_W-1:0]  pkt_count,
  output logic              err_proto,
  output state_t            state_dbg,
  output logic [CW-1:0]     credits_dbg
);

  state_t     state, state_next;
  logic       send;
  logic       credit_avail;
  logic       credit_overflow;
  logic       pkt_done;
  logic       frame_err;
  logic [1:0] ftype;

  assign ftype     = fifo_data[FLIT_W-1 -: 2];
  assign send      = tx_en && !fifo_empty && credit_avail && !reset;
  assign fifo_read = send;
  assign state_dbg = state;

  noc_credit_counter #(
    .CREDITS (CREDITS)
  ) u_credit (
    .clk      (clk),
    .reset    (reset),
    .inc      (credit_in),
    .dec      (send),
    .avail    (credit_avail),
    .overflow (credit_overflow),
    .count    (credits_dbg)
  );

  // Framing FSM: only a popped flit moves it. Malformed sequences are still
  // forwarded; they just raise the error flag.
  always_comb begin
    state_next = state;
    pkt_done   = 1'b0;
    frame_err  = 1'b0;
    if (send) begin
      case (state)
        S_IDLE: begin
          case (ftype)
            FT_HEAD:   state_next = S_PKT;
            FT_SINGLE: pkt_done   = 1'b1;
            default:   frame_err  = 1'b1;  // body/tail with no open packet
          endcase
        end
        S_PKT: begin
          case (ftype)
            FT_BODY: state_next = S_PKT;
            FT_TAIL: begin
              state_next = S_IDLE;
              pkt_done   = 1'b1;
            end
            // New head restarts the packet; the abandoned one is not counted.
            FT_HEAD: frame_err = 1'b1;
            default: begin  // single inside a packet
              state_next = S_IDLE;
              pkt_done   = 1'b1;
              frame_err  = 1'b1;
            end
          endcase
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      tx_busy    <= 1'b0;
      link_valid <= 1'b0;
      link_flit  <= '0;
      pkt_count  <= '0;
      err_proto  <= 1'b0;
    end else begin
      state      <= state_next;
      tx_busy    <= (state_next == S_PKT);
      link_valid <= send;
      if (send)      link_flit <= fifo_data;
      if (pkt_done)  pkt_count <= pkt_count + CNT_W'(1);
      if (frame_err || credit_overflow) err_proto <= 1'b1;
    end
  end

endmodule

// File: doc/noc_link_tx.md
Name: noc_link_tx

Overview:
Transmit end of a router output port. It drains a 16x16 flit FIFO through its read/empty/data_out interface and drives flits onto the inter-router link. Flow control is credit-based, sized to the downstream input FIFO depth. It tracks packet framing, counts completed packets and flags protocol errors. One instance sits between each output FIFO and its link.

Parameters:
FLIT_W, 16, flit width; must match the FIFO data width.
CREDITS, 16, downstream buffer depth and credit counter reset value.
CNT_W, 16, width of the packet counter.

Ports:
clk  input  1  clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
tx_en  input  1  permits popping new flits; sampled every cycle.
fifo_empty  input  1  FIFO empty flag.
fifo_data  input  FLIT_W  FIFO head-of-queue flit; combinational, valid while !fifo_empty.
fifo_read  output  1  FIFO pop strobe; combinational.
link_valid  output  1  flit on link_flit is valid this cycle; registered.
link_flit  output  FLIT_W  outgoing flit; registered.
credit_in  input  1  one-cycle pulse; downstream freed one buffer slot.
tx_busy  output  1  high while a multi-flit packet is open (state PKT).
pkt_count  output  CNT_W  completed packets sent; wraps modulo 2^CNT_W.
err_proto  output  1  sticky error flag; cleared only by reset.

Behaviour:
- Flit type is fifo_data[FLIT_W-1:FLIT_W-2]:
  - 2'b01 = head
  - 2'b00 = body
  - 2'b10 = tail
  - 2'b11 = single (head+tail)
- Reset values:
  - link_valid=0, link_flit=0, pkt_count=0, err_proto=0, tx_busy=0
  - state=IDLE, credit counter=CREDITS
  - fifo_read=0 whenever reset is high.
- Credit counter: width $clog2(CREDITS)+1.
- Send condition: send = tx_en && !fifo_empty && (credits != 0) && !reset. fifo_read = send.
- Latency: a flit popped in cycle N appears on link_flit with link_valid=1 in cycle N+1. link_valid=0 in any cycle following a non-send cycle. link_flit holds its last value when not valid.
- Throughput: one flit per cycle while credits and data are available.
- Credit update per cycle:
  - send only: -1
  - credit_in only: +1
  - both: unchanged
- Credit overflow: credit_in while credits==CREDITS and no send: counter stays at CREDITS and err_proto is set.
- Credit floor: the counter never goes below 0, because send requires credits != 0.
- FSM (IDLE, PKT), advanced only on send, keyed on the popped flit type:
  - IDLE + head -> PKT.
  - IDLE + single -> IDLE; pkt_count += 1.
  - IDLE + body or tail -> IDLE; err_proto set; flit still forwarded; no count.
  - PKT + body -> PKT.
  - PKT + tail -> IDLE; pkt_count += 1.
  - PKT + head -> PKT; err_proto set; treated as a new packet start; the old packet is not counted.
  - PKT + single -> IDLE; err_proto set; pkt_count += 1.
- tx_busy = (state == PKT), registered with the state.
- tx_en deassertion: stops popping at the next flit boundary, including mid-packet. State and credits are held and the packet resumes when tx_en returns.
- Reset mid-packet: everything returns to reset values in the next cycle. Flits already sent are not recalled. Downstream must be reset in the same cycle so credits stay consistent.
- pkt_count wraps from 2^CNT_W-1 to 0 without error.

Decomposition:
- Shared package (noc_pkg) holds:
  - flit type encodings FT_HEAD, FT_BODY, FT_TAIL, FT_SINGLE
  - the FLIT_W default
  - FSM state constants S_IDLE, S_PKT
- One natural sub-module: noc_credit_counter. It has inputs inc/dec, output avail (count != 0) and output overflow pulse, and is parameterised by CREDITS.
- The FSM, output register and packet counter stay in noc_link_tx.

Test Plan:
1. Reset, then push head/body/body/tail (0x4001, 0x0002, 0x0003, 0x8004) with tx_en=1 -> link_valid high for 4 consecutive cycles, starting one cycle after the first fifo_read, flits in order; tx_busy high for 3 cycles; pkt_count=1; credits=12.
2. Queue 20 single flits (0xC000+i), no credit_in -> exactly 16 flits sent; fifo_read stays 0 afterwards. Then pulse credit_in 4 times -> 4 more flits sent; pkt_count=20.
3. Credits=0 with a flit waiting; pulse credit_in -> fifo_read asserted in the same cycle the counter becomes 1; flit appears on the next cycle. Separately, a simultaneous send and credit_in at credits=5 leaves credits=5.
4. Send head 0x4010, drop tx_en for 3 cycles, then raise it and send tail 0x8011 -> no link_valid during the gap; tx_busy stays 1; pkt_count goes 0->1 only after the tail.
5. Body 0x0005 while IDLE -> flit forwarded, err_proto=1 and remains set. Then credit_in at credits=16 with no send -> counter stays 16. Then reset -> err_proto=0.
6. Reset asserted mid-packet after the head -> next cycle: tx_busy=0, link_valid=0, credits=16, pkt_count=0; fifo_read=0 while reset is high.
